// File: rtl/axis_zip_sched_pkg.sv
// Shared types for the zip-record round-robin scheduler: FSM states and the
// record layout handed to the expansion engine.
package axis_zip_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } sched_state_e;

  localparam int ASIZE_DEF = 8;
  localparam int LSIZE_DEF = 8;

  // Field order of a record; the scheduler itself slices by parameter width.
  typedef struct packed {
    logic [ASIZE_DEF-1:0] start;
    logic [LSIZE_DEF-1:0] len_m1;
  } rec_t;

endpackage

// File: rtl/axis_zip_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// found by scanning a doubled copy of the request vector.
module rr_pick #(
  parameter int NUM = 4,
  parameter int IDW = $clog2(NUM)
) (
  input  logic [NUM-1:0] req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [NUM-1:0] gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [2*NUM-1:0] dbl;
  int               hit;
  int               pos;

  always_comb begin
    dbl   = {req_i, req_i};
    hit   = 0;
    any_o = |req_i;
    // Descending scan so the smallest offset from ptr is the last one kept.
    for (int i = NUM - 1; i >= 0; i--) begin
      if (dbl[int'(ptr_i) + i]) hit = i;
    end
    pos = int'(ptr_i) + hit;
    if (pos >= NUM) pos = pos - NUM;
    idx_o = pos[IDW-1:0];
    gnt_o = '0;
    if (any_o) gnt_o[pos[IDW-1:0]] = 1'b1;
  end

endmodule

// File: rtl/axis_zip_rr_scheduler.sv
// Shares one zip-record expansion engine between NUM requesters, holding the
// grant until the engine's burst ends and flagging burst-length mismatches.
module axis_zip_rr_scheduler
  import axis_zip_sched_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int ASIZE = 8,
  parameter int LSIZE = 8,
  parameter int IDW   = $clog2(NUM)
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM-1:0]                req_valid,
  input  logic [NUM*(ASIZE+LSIZE)-1:0]  req_data,
  output logic [NUM-1:0]                req_ready,
  output logic                          zip_tvalid,
  output logic [ASIZE+LSIZE-1:0]        zip_tdata,
  input  logic                          zip_tready,
  input  logic                          unzip_tvalid,
  input  logic                          unzip_tready,
  input  logic                          unzip_tlast,
  output logic [IDW-1:0]                cur_id,
  output logic                          busy,
  output logic                          err_len
);

  localparam int             RW      = ASIZE + LSIZE;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM - 1);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [RW-1:0]  rec_q, rec_d;
  logic [LSIZE:0] beat_q, beat_d;
  logic [LSIZE:0] beat_inc, exp_len;
  logic [NUM-1:0] win_gnt;
  logic [IDW-1:0] win_idx;
  logic           win_any;
  logic           beat;
  logic           counted;
  logic           len_hit;

  rr_pick #(.NUM(NUM), .IDW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign beat     = unzip_tvalid & unzip_tready;
  assign beat_inc = beat_q + (LSIZE+1)'(1);
  assign exp_len  = {1'b0, rec_q[LSIZE-1:0]} + (LSIZE+1)'(1);
  assign len_hit  = (beat_inc == exp_len);
  // A beat seen before the engine took the record does not belong to it.
  assign counted  = beat && ((state_q == BUSY) || ((state_q == ISSUE) && zip_tready));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      rec_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      rec_q    <= rec_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_id_d   = cur_id_q;
    rec_d      = rec_q;
    beat_d     = beat_q;
    req_ready  = '0;
    zip_tvalid = 1'b0;
    err_len    = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gating keeps the pop strobe quiet while reset is held.
        if (rst_n) req_ready = win_gnt;
        if (win_any) begin
          rec_d    = req_data[int'(win_idx)*RW +: RW];
          cur_id_d = win_idx;
          beat_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        zip_tvalid = 1'b1;
        if (zip_tready) state_d = BUSY;
        if (beat && !zip_tready) err_len = 1'b1;
      end
      BUSY: begin
      end
      default: state_d = IDLE;
    endcase

    if (counted) begin
      beat_d = beat_inc;
      if (unzip_tlast) begin
        err_len = !len_hit;
        state_d = IDLE;
        ptr_d   = (cur_id_q == LAST_ID) ? '0 : cur_id_q + IDW'(1);
      end else begin
        err_len = len_hit;
      end
    end
  end

  assign zip_tdata = rec_q;
  assign cur_id    = cur_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_axis_zip_rr_scheduler.sv
// Directed bench for axis_zip_rr_scheduler: the bench plays both the
// requesters and the expansion engine, with a scoreboard of issued records.
module tb_axis_zip_rr_scheduler;

  localparam int NUM   = 4;
  localparam int ASIZE = 8;
  localparam int LSIZE = 8;
  localparam int IDW   = 2;
  localparam int RW    = ASIZE + LSIZE;

  logic                 clock = 1'b0;
  logic                 rst_n;
  logic [NUM-1:0]       req_valid;
  logic [NUM*RW-1:0]    req_data;
  logic [NUM-1:0]       req_ready;
  logic                 zip_tvalid;
  logic [RW-1:0]        zip_tdata;
  logic                 zip_tready;
  logic                 unzip_tvalid;
  logic                 unzip_tready;
  logic                 unzip_tlast;
  logic [IDW-1:0]       cur_id;
  logic                 busy;
  logic                 err_len;

  typedef struct {
    int          id;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   nextp    = 0;

  axis_zip_rr_scheduler #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDW(IDW)
  ) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .zip_tvalid   (zip_tvalid),
    .zip_tdata    (zip_tdata),
    .zip_tready   (zip_tready),
    .unzip_tvalid (unzip_tvalid),
    .unzip_tready (unzip_tready),
    .unzip_tlast  (unzip_tlast),
    .cur_id       (cur_id),
    .busy         (busy),
    .err_len      (err_len)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(output exp_t e);
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected at least 1");
    end
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.id   = -1;
      e.data = 'x;
    end
  endtask

  task automatic set_rec(input int i, input logic [7:0] start, input logic [7:0] len_m1);
    req_data[i*RW +: RW] = {start, len_m1};
  endtask

  task automatic idle_cycle(input logic [NUM-1:0] exp_ready);
    @(negedge clock);
    chk("idle_busy", busy, 0);
    chk("idle_tvalid", zip_tvalid, 0);
    chk("idle_ready", req_ready, exp_ready);
    @(posedge clock); #1;
  endtask

  // Expected record comes from what the bench itself put on req_data.
  task automatic grant(input int id);
    exp_t e;
    e.id   = id;
    e.data = req_data[id*RW +: RW];
    sb.push_back(e);
    idle_cycle(NUM'(1 << id));
  endtask

  // Starts in ISSUE; returns right after the tlast edge (DUT back in IDLE).
  task automatic run_burst(input int id, input int stall, input int stray_at,
                           input int nbeats, input int err_a, input int err_b);
    exp_t e;
    take(e);
    for (int s = 0; s < stall; s++) begin
      zip_tready   = 1'b0;
      unzip_tvalid = (s == stray_at);
      unzip_tready = 1'b1;
      unzip_tlast  = 1'b0;
      @(negedge clock);
      chk("stall_tvalid", zip_tvalid, 1);
      chk("stall_tdata", zip_tdata, e.data);
      chk("stall_err", err_len, (s == stray_at));
      chk("stall_ready", req_ready, 0);
      @(posedge clock); #1;
    end
    zip_tready   = 1'b1;
    unzip_tvalid = 1'b0;
    unzip_tlast  = 1'b0;
    @(negedge clock);
    chk("hs_tvalid", zip_tvalid, 1);
    chk("hs_tdata", zip_tdata, e.data);
    chk("hs_id", cur_id, e.id);
    @(posedge clock); #1;
    zip_tready = 1'b0;
    for (int b = 1; b <= nbeats; b++) begin
      unzip_tvalid = 1'b1;
      unzip_tready = 1'b1;
      unzip_tlast  = (b == nbeats);
      @(negedge clock);
      chk("beat_err", err_len, (b == err_a) || (b == err_b));
      chk("beat_id", cur_id, id);
      chk("beat_busy", busy, 1);
      chk("beat_tvalid", zip_tvalid, 0);
      @(posedge clock); #1;
    end
    unzip_tvalid = 1'b0;
    unzip_tlast  = 1'b0;
    nextp = (id + 1) % NUM;
  endtask

  initial begin
    exp_t e;
    int   g;
    rst_n        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    zip_tready   = 1'b0;
    unzip_tvalid = 1'b0;
    unzip_tready = 1'b0;
    unzip_tlast  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", zip_tvalid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_len, 0);
    chk("rst_id", cur_id, 0);
    chk("rst_tdata", zip_tdata, 0);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;

    // Single requester, four-beat burst with a well-formed tlast.
    set_rec(0, 8'h10, 8'd3);
    req_valid = 4'b0001;
    grant(0);
    req_valid = '0;
    run_burst(0, 0, -1, 4, 0, 0);
    idle_cycle('0);

    // Everyone valid, single-beat records: strict rotation with one bubble.
    for (int i = 0; i < NUM; i++) set_rec(i, 8'(8'h20 + i), 8'd0);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      g = nextp;
      grant(g);
      run_burst(g, 0, -1, 1, 0, 0);
    end

    // Engine stalls five cycles; a stray beat in the stall is flagged.
    g = nextp;
    grant(g);
    run_burst(g, 5, 2, 1, 0, 0);
    req_valid = '0;
    idle_cycle('0);

    // Early tlast on beat 2 of a 4-beat record.
    set_rec(1, 8'h44, 8'd3);
    req_valid = 4'b0010;
    grant(1);
    req_valid = '0;
    run_burst(1, 0, -1, 2, 2, 0);
    idle_cycle('0);

    // Missing tlast on beat 4, tlast finally on beat 5.
    set_rec(3, 8'h5A, 8'd3);
    req_valid = 4'b1000;
    grant(3);
    req_valid = '0;
    run_burst(3, 1, -1, 5, 4, 5);
    idle_cycle('0);

    // Reset mid-burst with requester 2 owning the engine.
    set_rec(2, 8'h77, 8'd7);
    set_rec(0, 8'h01, 8'd1);
    req_valid = 4'b0100;
    grant(2);
    req_valid = 4'b0101;
    take(e);
    zip_tready = 1'b1;
    @(negedge clock);
    chk("mid_hs_tdata", zip_tdata, e.data);
    @(posedge clock); #1;
    zip_tready   = 1'b0;
    unzip_tvalid = 1'b1;
    unzip_tready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      chk("mid_id", cur_id, 2);
      chk("mid_busy", busy, 1);
      @(posedge clock); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_id", cur_id, 0);
    chk("arst_tvalid", zip_tvalid, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_err", err_len, 0);
    chk("arst_tdata", zip_tdata, 0);
    @(posedge clock); #1;
    unzip_tvalid = 1'b0;
    rst_n        = 1'b1;
    grant(0);
    req_valid = '0;
    run_burst(0, 0, -1, 2, 0, 0);
    idle_cycle('0);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_zip_rr_scheduler.md
# axis_zip_rr_scheduler

Round-robin scheduler that shares one zip-record expansion engine (start/length record in, address stream out) between NUM requesters. It accepts one record at a time from the granted requester, forwards it to the engine, and holds the grant until the engine's expanded burst ends with tlast. It tags the burst with the owner id and checks the burst length. It sits between the per-client record queues and the single expansion engine instance.

## Interface
- NUM, 4: number of requesters, 2..16.
- ASIZE, 8: start-address field width.
- LSIZE, 8: length field width. The field holds length-1, so burst length is 1..2^LSIZE.
- IDW, $clog2(NUM): width of the owner id.

- clock  in  1  single clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM  per-requester record valid.
- req_data  in  NUM x (ASIZE+LSIZE)  per-requester record: {start[ASIZE-1:0], len_m1[LSIZE-1:0]}.
- req_ready  out  NUM  per-requester pop strobe; at most one bit high per cycle.
- zip_tvalid  out  1  record valid to the engine.
- zip_tdata  out  ASIZE+LSIZE  record to the engine.
- zip_tready  in  1  engine accepts the record.
- unzip_tvalid  in  1  engine output beat valid (snooped).
- unzip_tready  in  1  downstream ready on the engine output (snooped).
- unzip_tlast  in  1  last beat of the expanded burst (snooped).
- cur_id  out  IDW  owner of the burst in flight; used as tuser/tdest downstream.
- busy  out  1  high in ISSUE and BUSY.
- err_len  out  1  one-cycle pulse on a burst-length mismatch.

## Operation
- States:
  - IDLE: no record outstanding.
  - ISSUE: zip_tvalid is high, waiting for zip_tready.
  - BUSY: record accepted, waiting for the burst to end.
- Arbitration in IDLE:
  - Search req_valid starting at ptr, ptr+1, … (mod NUM); the first valid index wins.
  - req_ready[win] is driven combinationally high in that same cycle.
  - req_data[win] is latched into rec_q, win into cur_id, and the state moves to ISSUE.
  - If no req_valid bit is set, stay in IDLE and all req_ready bits are 0.
- ISSUE:
  - zip_tvalid=1 and zip_tdata=rec_q, held stable until zip_tready.
  - On zip_tready, go to BUSY.
- Burst beat: a cycle with unzip_tvalid && unzip_tready, counted in ISSUE and BUSY.
- Beat counter beat_q:
  - Width LSIZE+1.
  - Cleared on entry to ISSUE; incremented on each beat.
  - exp = rec_q.len_m1 + 1, zero-extended to LSIZE+1.
- Burst end (tlast beat):
  - The tlast beat ends the burst.
  - Go to IDLE and set ptr = (cur_id+1) mod NUM, which is the wrap-around.
  - If the tlast beat arrives in ISSUE together with zip_tready, go directly to IDLE.
- Length check:
  - Pulse err_len if the tlast beat arrives with beat_q+1 != exp.
  - Pulse err_len if a beat without tlast arrives with beat_q+1 == exp. The grant is still held until tlast.
  - Pulse err_len if a beat arrives in ISSUE before zip_tready. That beat is not counted.
- The scheduler never drops or modifies records. rec_q is passed to the engine bit-exact.

## Timing
- Reset values (asynchronous, rst_n low):
  - state=IDLE, ptr=0, cur_id=0, rec_q=0, beat_q=0.
  - zip_tvalid=0, req_ready=0, busy=0, err_len=0.
- Latency:
  - req_valid to req_ready: 0 cycles when IDLE.
  - req_ready pop to zip_tvalid: 1 cycle.
  - Last beat to next req_ready: 1 cycle, because IDLE takes one cycle, so there is 1 bubble.
- Handshakes:
  - zip_tvalid never deasserts without zip_tready.
  - zip_tdata is constant while zip_tvalid is high.
  - req_ready is high only in IDLE.
- cur_id is stable from the cycle after the pop until the cycle after the tlast beat.
- A requester that deasserts req_valid while another is granted is simply skipped next round. There is no starvation: the worst-case wait is NUM-1 bursts.
- If rst_n is asserted mid-burst, everything returns to the reset values immediately. The engine is reset by the same rst_n.

## Structure
- Package axis_zip_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, BUSY} sched_state_e.
  - A rec_t packed-struct template documenting the {start, len_m1} field order.
- Sub-module rr_pick #(NUM):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and its binary index.
  - Purely combinational, using a double-width rotate-and-priority scheme.

## Test plan
- Single requester 0 sends record {start=8'h10, len_m1=8'd3}, engine always ready.
  - req_ready[0] pulses once; zip_tdata=16'h1003 one cycle later.
  - cur_id=0 for 4 beats; no err_len; IDLE after the tlast beat.
- All 4 requesters valid continuously with len_m1=0.
  - Grants go in order 0,1,2,3,0,…, with exactly one req_ready per burst.
  - One bubble cycle between bursts.
- zip_tready held low for 5 cycles in ISSUE.
  - zip_tvalid stays high and zip_tdata stays stable.
  - No req_ready pulse occurs in that window.
- Engine emits tlast on beat 2 when exp=4: err_len pulses once and the state returns to IDLE.
- Engine emits beat 4 of exp=4 without tlast, then tlast on beat 5: err_len pulses on beat 4, and the grant is released after beat 5.
- rst_n is pulsed low during BUSY with cur_id=2.
  - All outputs go to their reset values asynchronously.
  - After release, requester 0 is granted first (ptr=0).
